pll_lock_sequencer: RTL and testbench
=====================================

# pll_lock_sequencer

Reset and lock controller for the single-output PLL that derives the 5 MHz sampling clock from the 50 MHz board reference. It holds the PLL in reset for a minimum pulse, waits for `locked` with a timeout and bounded retries, and qualifies lock over a stability window. It releases the downstream system reset request only once lock is stable, and re-sequences the PLL on loss of lock or on software request. It runs entirely on the free-running reference clock, so it keeps operating while the PLL output is absent.

## Interface
- `RST_CYCLES`, 10: cycles `pll_rst` is held high per attempt (200 ns at 50 MHz).
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK before an attempt fails (1 ms).
- `STABLE_CYCLES`, 1024: consecutive synchronised-lock cycles required before RUN.
- `MAX_RETRY`, 3: failed attempts tolerated; the next timeout enters FAIL.
- `refclk`, input, 1: 50 MHz reference clock; all logic on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `pll_locked`, input, 1: PLL `locked`; asynchronous to `refclk`.
- `relock_req`, input, 1: single-cycle request to re-sequence the PLL; synchronous.
- `pll_rst`, output, 1: drives the PLL `rst` pin.
- `sys_rst`, output, 1: downstream reset request; the consumer synchronises it into `outclk_0`.
- `lock_ok`, output, 1: high only in RUN.
- `fail`, output, 1: high only in FAIL.
- `retry_cnt`, output, 2: failed attempts in the current sequence.
- `loss_cnt`, output, 8: saturating count of lock losses seen in RUN.

## Operation
- `pll_locked` passes through a 2-FF synchroniser (`lk_s`) before any use.
- One shared counter `cnt` is sized `$clog2` of the largest of the three cycle parameters. It clears on every state change.
- States and transitions:
  - RESET_PLL: `pll_rst`=1. When `cnt`==RST_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: `pll_rst`=0.
    - `lk_s`=1: go to STABLE.
    - `cnt`==LOCK_TIMEOUT-1 with `retry_cnt`<MAX_RETRY: increment `retry_cnt`, go to RESET_PLL.
    - The same timeout with `retry_cnt`==MAX_RETRY: go to FAIL.
  - STABLE:
    - `lk_s`=0: return to WAIT_LOCK. The timeout restarts and `retry_cnt` is unchanged.
    - `cnt`==STABLE_CYCLES-1 with `lk_s`=1: go to RUN and clear `retry_cnt`.
  - RUN: `sys_rst`=0, `lock_ok`=1. If `lk_s`=0, increment `loss_cnt` (saturates at 255) and go to RESET_PLL.
  - FAIL: `pll_rst`=1, `sys_rst`=1, `fail`=1. Exit only by `rst` or `relock_req`.
- `sys_rst`=1 in every state except RUN.
- `relock_req`:
  - In WAIT_LOCK, STABLE, RUN or FAIL: go to RESET_PLL and clear `retry_cnt`.
  - In RESET_PLL: ignored.
  - In RUN it does not increment `loss_cnt`.
- Simultaneous events:
  - `lk_s` rising on the timeout cycle: lock wins, go to STABLE.
  - `relock_req` together with lock loss in RUN: go to RESET_PLL and increment `loss_cnt`.

## Timing
- All outputs are registered and derived from the current state; no combinational input-to-output path.
- Reset values: state RESET_PLL, `cnt`=0, `pll_rst`=1, `sys_rst`=1, `lock_ok`=0, `fail`=0, `retry_cnt`=0, `loss_cnt`=0, synchroniser 0.
- `pll_rst` high pulse is exactly RST_CYCLES cycles per attempt. The cycles while `rst` is asserted are not counted.
- From `pll_locked` rising (already stable) to `sys_rst` falling: 2 synchroniser cycles + 1 cycle WAIT_LOCK→STABLE + STABLE_CYCLES cycles.
- From `pll_locked` falling in RUN to `sys_rst` rising: 3 cycles (2 synchroniser + 1 state register).
- `rst` asserted mid-sequence returns everything to reset values immediately, including `loss_cnt`.

## Configuration
- `PLL_SEQ_LOSS_CNT_EN` defined: the `loss_cnt` register and incrementer are built as described.
- Undefined: `loss_cnt` is tied to 8'd0 and no counter logic is synthesised. All other behaviour is identical.

## Test plan
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2, with the macro defined.
- Nominal: release `rst`; raise `pll_locked` 10 cycles after `pll_rst` falls.
  - `pll_rst` high for exactly 4 cycles.
  - `sys_rst` falls 2+1+8 cycles after the `pll_locked` edge.
  - `lock_ok`=1, `retry_cnt`=0.
- Timeout and retries: hold `pll_locked`=0.
  - Three 4-cycle `pll_rst` pulses, separated by 20-cycle waits.
  - `retry_cnt` steps 1 then 2; then FAIL with `fail`=1, `pll_rst`=1.
  - `relock_req` then clears `retry_cnt` to 0 and restarts the sequence.
- Glitch during STABLE: drop `pll_locked` for 1 cycle at STABLE cycle 5.
  - State returns to WAIT_LOCK and `sys_rst` stays 1.
  - On relock, a full 8-cycle window is required again.
- Loss in RUN: drop `pll_locked`.
  - `sys_rst` rises 3 cycles later; `loss_cnt` goes 0→1; a new `pll_rst` pulse follows.
  - Repeat 256 losses: `loss_cnt`=255.
- Async reset mid-WAIT_LOCK: assert `rst` between clock edges.
  - All outputs return to reset values before the next edge.
- Macro undefined: rerun the loss-in-RUN scenario.
  - `loss_cnt` stays 0; all other results unchanged.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for the 5 MHz sampling-clock PLL, clocked from the free-running reference.
// Define PLL_SEQ_LOSS_CNT_EN to build the saturating lock-loss counter; otherwise loss_cnt reads 0.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 10,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       lock_ok,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       MAX_R       = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       retry_nxt;
  logic             pll_rst_nxt, sys_rst_nxt, lock_ok_nxt, fail_nxt;
  logic             lk_p0, lk_s;

  // Stage p0/s: two-flop synchroniser for the asynchronous PLL lock flag
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lk_p0 <= 1'b0;
      lk_s  <= 1'b0;
    end else begin
      lk_p0 <= pll_locked;
      lk_s  <= lk_p0;
    end
  end

  // State register; outputs are registered from the next-state decode so they track state exactly
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= S_RESET_PLL;
      cnt       <= '0;
      retry_cnt <= 2'd0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      lock_ok   <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      pll_rst   <= pll_rst_nxt;
      sys_rst   <= sys_rst_nxt;
      lock_ok   <= lock_ok_nxt;
      fail      <= fail_nxt;
    end
  end

  assign cnt_nxt = (state_nxt != state) ? '0 : cnt + CNT_W'(1);

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    case (state)
      S_RESET_PLL: begin
        if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (relock_req) begin
          state_nxt = S_RESET_PLL;
          retry_nxt = 2'd0;
        end else if (lk_s) begin
          state_nxt = S_STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          if (retry_cnt < MAX_R) begin
            state_nxt = S_RESET_PLL;
            retry_nxt = retry_cnt + 2'd1;
          end else begin
            state_nxt = S_FAIL;
          end
        end
      end
      S_STABLE: begin
        if (relock_req) begin
          state_nxt = S_RESET_PLL;
          retry_nxt = 2'd0;
        end else if (!lk_s) begin
          state_nxt = S_WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = S_RUN;
          retry_nxt = 2'd0;
        end
      end
      S_RUN: begin
        if (!lk_s || relock_req) state_nxt = S_RESET_PLL;
        if (relock_req) retry_nxt = 2'd0;
      end
      S_FAIL: begin
        if (relock_req) begin
          state_nxt = S_RESET_PLL;
          retry_nxt = 2'd0;
        end
      end
      default: state_nxt = S_RESET_PLL;
    endcase
  end

  always_comb begin
    pll_rst_nxt = 1'b0;
    sys_rst_nxt = 1'b1;
    lock_ok_nxt = 1'b0;
    fail_nxt    = 1'b0;
    case (state_nxt)
      S_RESET_PLL: pll_rst_nxt = 1'b1;
      S_RUN: begin
        sys_rst_nxt = 1'b0;
        lock_ok_nxt = 1'b1;
      end
      S_FAIL: begin
        pll_rst_nxt = 1'b1;
        fail_nxt    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PLL_SEQ_LOSS_CNT_EN
  // A lock loss seen in RUN always re-sequences, even when it coincides with a relock request
  logic loss_inc;
  assign loss_inc = (state == S_RUN) && !lk_s;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      loss_cnt <= 8'd0;
    end else if (loss_inc && (loss_cnt != 8'hFF)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end
`else
  assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios with randomized timing,
// every cycle compared against a timestamp-based behavioural model.
module tb_pll_lock_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;
`ifdef PLL_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif
  localparam logic [31:0] RST_VEC = 32'h0000_3000;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, sys_rst, lock_ok, fail;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 refclk = ~refclk;

  pll_lock_sequencer #(
    .RST_CYCLES(RST_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .pll_locked(pll_locked),
    .relock_req(relock_req),
    .pll_rst(pll_rst),
    .sys_rst(sys_rst),
    .lock_ok(lock_ok),
    .fail(fail),
    .retry_cnt(retry_cnt),
    .loss_cnt(loss_cnt)
  );

  // Behavioural model: phase plus the edge index at which it began; lock seen through a 2-deep delay line
  typedef enum int {M_RST, M_WAIT, M_STABLE, M_RUN, M_FAIL} mphase_t;
  mphase_t ph = M_RST;
  int      cyc = 0;
  int      ph_start = 0;
  int      m_retry = 0;
  int      m_loss = 0;
  bit      hist[$];

  task automatic model_reset();
    ph = M_RST;
    ph_start = cyc;
    m_retry = 0;
    m_loss = 0;
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
  endtask

  task automatic model_edge(input bit lk_in, input bit rq);
    int      dwell;
    bit      lk;
    mphase_t nxt;
    cyc++;
    dwell = cyc - ph_start;
    lk = hist.pop_front();
    hist.push_back(lk_in);
    nxt = ph;
    case (ph)
      M_RST: if (dwell == RST_CYCLES) nxt = M_WAIT;
      M_WAIT: begin
        if (rq) begin
          nxt = M_RST;
          m_retry = 0;
        end else if (lk) begin
          nxt = M_STABLE;
        end else if (dwell == LOCK_TIMEOUT) begin
          if (m_retry < MAX_RETRY) begin
            m_retry++;
            nxt = M_RST;
          end else begin
            nxt = M_FAIL;
          end
        end
      end
      M_STABLE: begin
        if (rq) begin
          nxt = M_RST;
          m_retry = 0;
        end else if (!lk) begin
          nxt = M_WAIT;
        end else if (dwell == STABLE_CYCLES) begin
          nxt = M_RUN;
          m_retry = 0;
        end
      end
      M_RUN: begin
        if (!lk || rq) nxt = M_RST;
        if (rq) m_retry = 0;
        if (!lk && LOSS_EN && m_loss < 255) m_loss++;
      end
      M_FAIL: begin
        if (rq) begin
          nxt = M_RST;
          m_retry = 0;
        end
      end
      default: nxt = M_RST;
    endcase
    if (nxt != ph) ph_start = cyc;
    ph = nxt;
  endtask

  function automatic logic [31:0] exp_vec();
    logic [13:0] v;
    v = {(ph == M_RST) || (ph == M_FAIL), ph != M_RUN, ph == M_RUN, ph == M_FAIL,
         2'(m_retry), 8'(m_loss)};
    return 32'(v);
  endfunction

  function automatic logic [31:0] obs_vec();
    return 32'({pll_rst, sys_rst, lock_ok, fail, retry_cnt, loss_cnt});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    model_edge(pll_locked, relock_req);
    @(posedge refclk);
    #1;
    chk("outs", obs_vec(), exp_vec());
  endtask

  task automatic rst_step();
    @(posedge refclk);
    #1;
    chk("reset_hold", obs_vec(), RST_VEC);
  endtask

  // Number of edges until pll_rst changes level (bounded)
  task automatic run_len(output int n);
    logic lvl;
    lvl = pll_rst;
    n = 0;
    do begin
      step();
      n++;
    end while (pll_rst === lvl && n < 200);
  endtask

  task automatic wait_lock();
    int n;
    n = 0;
    while (lock_ok !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("lock_wait", 32'(lock_ok), 32'd1);
  endtask

  initial begin
    int n;
    int d;
    model_reset();
    repeat (3) rst_step();
    rst = 1'b0;
    model_reset();

    // Timeout and retries with the PLL never locking
    run_len(n);
    chk("prst_pulse0", 32'(n), 32'(RST_CYCLES));
    for (int i = 1; i <= MAX_RETRY; i++) begin
      run_len(n);
      chk("wait_gap", 32'(n), 32'(LOCK_TIMEOUT));
      chk("retry_step", 32'(retry_cnt), 32'(i));
      run_len(n);
      chk("prst_pulse", 32'(n), 32'(RST_CYCLES));
    end
    run_len(n);
    chk("wait_gap_last", 32'(n), 32'(LOCK_TIMEOUT));
    chk("fail_flags", 32'({fail, pll_rst, sys_rst}), 32'd7);
    repeat (6) step();
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    chk("relock_clr", 32'({fail, retry_cnt}), 32'd0);
    run_len(n);
    chk("relock_pulse", 32'(n), 32'(RST_CYCLES));

    // Asynchronous reset in the middle of WAIT_LOCK
    d = $urandom_range(1, 15);
    repeat (d) step();
    #3 rst = 1'b1;
    #1 chk("async_rst_wait", obs_vec(), RST_VEC);
    model_reset();
    repeat (2) rst_step();
    rst = 1'b0;
    model_reset();

    // Nominal lock: raise locked 10 cycles after pll_rst falls
    run_len(n);
    chk("prst_width", 32'(n), 32'(RST_CYCLES));
    repeat (10) step();
    pll_locked = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (sys_rst && n < 100);
    chk("lock_to_sysrst", 32'(n), 32'(2 + 1 + STABLE_CYCLES));
    chk("run_flags", 32'({lock_ok, retry_cnt}), 32'd4);

    // Loss of lock in RUN
    pll_locked = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!sys_rst && n < 100);
    chk("loss_to_sysrst", 32'(n), 32'd3);
    chk("loss_cnt_first", 32'(loss_cnt), LOSS_EN ? 32'd1 : 32'd0);
    run_len(n);
    chk("loss_prst", 32'(n), 32'(RST_CYCLES));

    // Single-cycle glitch during STABLE forces a full window again
    repeat ($urandom_range(0, 5)) step();
    pll_locked = 1'b1;
    d = $urandom_range(1, 7);
    repeat (d) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (sys_rst && n < 100);
    chk("glitch_window", 32'(n), 32'(2 + 1 + STABLE_CYCLES));

    // Software relock in RUN does not count as a loss
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    chk("relock_run", 32'({sys_rst, pll_rst, loss_cnt}), LOSS_EN ? 32'h301 : 32'h300);
    wait_lock();

    // Repeated losses, sometimes coinciding with a relock request, until loss_cnt saturates
    for (int i = 0; i < 255; i++) begin
      bit both;
      both = ($urandom_range(0, 3) == 0);
      d = $urandom_range(1, 3);
      pll_locked = 1'b0;
      for (int j = 1; j <= 3; j++) begin
        if (both && j == 3) relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        if (j == d) pll_locked = 1'b1;
      end
      wait_lock();
    end
    chk("loss_sat", 32'(loss_cnt), LOSS_EN ? 32'd255 : 32'd0);

    // Asynchronous reset in RUN clears the loss counter as well
    #3 rst = 1'b1;
    #1 chk("async_rst_run", obs_vec(), RST_VEC);
    model_reset();
    rst_step();
    rst = 1'b0;
    model_reset();
    repeat (20) step();
    chk("relock_after_rst", 32'({lock_ok, loss_cnt}), 32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
